// File: rtl/sweep_pkg.sv
// Shared definitions for the triangle-sweep initiator: one-hot state codes,
// error codes and small state-decoding helpers.
package sweep_pkg;

  localparam int NUM_ST = 5;

  typedef logic [NUM_ST-1:0] state_t;

  localparam state_t ST_IDLE = 5'b00001;
  localparam state_t ST_UP   = 5'b00010;
  localparam state_t ST_DOWN = 5'b00100;
  localparam state_t ST_DONE = 5'b01000;
  localparam state_t ST_ERR  = 5'b10000;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_LIMITS  = 2'b01;
  localparam err_code_t ERR_OVFLW   = 2'b10;
  localparam err_code_t ERR_TIMEOUT = 2'b11;

  // True while the counter is being driven (UP or DOWN).
  function automatic logic in_sweep(input state_t s);
    return (s == ST_UP) || (s == ST_DOWN);
  endfunction

endpackage

// File: rtl/sweep_watchdog.sv
// Stall watchdog for sweep_ctrl: counts sweep cycles in which count_in has not
// moved and flags a timeout on the TIMEOUT_CYCLES-th consecutive stalled cycle.
module sweep_watchdog
  import sweep_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  state_t                   state,
  input  logic [COUNTER_WIDTH-1:0] count_in,
  output logic                     timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  state_t                   st_prev_q;
  logic [COUNTER_WIDTH-1:0] cnt_prev_q;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     stall;

  // A cycle only counts as stalled if the state is unchanged as well, so every
  // UP/DOWN entry restarts the window.
  always_comb begin
    stall = in_sweep(state) && (state == st_prev_q) && (count_in == cnt_prev_q);
    wd_d  = '0;
    if (stall) begin
      wd_d = (wd_q != WD_LIMIT) ? wd_q + 1'b1 : wd_q;
    end
    timeout = (wd_d == WD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_prev_q  <= ST_IDLE;
      cnt_prev_q <= '0;
      wd_q       <= '0;
    end else begin
      st_prev_q  <= state;
      cnt_prev_q <= count_in;
      wd_q       <= wd_d;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle-sweep initiator for the up/down counter: drives act/up_dwn_n,
// watches count/ovflw and reports busy/done/err to the host.
// Optional stall watchdog enabled by defining SWEEP_TIMEOUT_EN.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 4,
  parameter int LOOP_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] hi_lim,
  input  logic [COUNTER_WIDTH-1:0] lo_lim,
  input  logic [LOOP_WIDTH-1:0]    loops,
  input  logic [COUNTER_WIDTH-1:0] count_in,
  input  logic                     ovflw_in,
  output logic                     act,
  output logic                     up_dwn_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [LOOP_WIDTH-1:0]    loops_done
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sweep_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] hi_q, hi_d;
  logic [COUNTER_WIDTH-1:0] lo_q, lo_d;
  logic [LOOP_WIDTH-1:0]    loops_q, loops_d;
  logic [LOOP_WIDTH-1:0]    loops_done_q, loops_done_d;
  logic [LOOP_WIDTH-1:0]    ld_inc;
  err_code_t                err_code_q, err_code_d;
  logic                     act_q, act_d;
  logic                     up_dwn_n_q, up_dwn_n_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     timeout;

`ifdef SWEEP_TIMEOUT_EN
  sweep_watchdog #(
    .COUNTER_WIDTH  (COUNTER_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .count_in (count_in),
    .timeout  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State register; limits and counters travel with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      loops_q      <= '0;
      loops_done_q <= '0;
      err_code_q   <= ERR_NONE;
      act_q        <= 1'b0;
      up_dwn_n_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      loops_q      <= loops_d;
      loops_done_q <= loops_done_d;
      err_code_q   <= err_code_d;
      act_q        <= act_d;
      up_dwn_n_q   <= up_dwn_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next state. Overflow outranks timeout, and both outrank a turn.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    loops_d      = loops_q;
    loops_done_d = loops_done_q;
    err_code_d   = err_code_q;
    ld_inc       = (loops_done_q != loops_q) ? loops_done_q + 1'b1 : loops_done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hi_d         = hi_lim;
          lo_d         = lo_lim;
          loops_d      = loops;
          loops_done_d = '0;
          if (hi_lim <= lo_lim) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LIMITS;
          end else if (loops == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_UP;
          end
        end
      end

      ST_UP: begin
        if (ovflw_in) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVFLW;
        end else if (timeout) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end else if (count_in >= hi_q) begin
          state_d = ST_DOWN;
        end
      end

      ST_DOWN: begin
        if (ovflw_in) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVFLW;
        end else if (timeout) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end else if (count_in <= lo_q) begin
          loops_done_d = ld_inc;
          state_d      = (ld_inc == loops_q) ? ST_DONE : ST_UP;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      // Sticky until reset, like the counter's own overflow flag.
      ST_ERR: state_d = ST_ERR;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    act_d      = 1'b0;
    up_dwn_n_d = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_d)
      ST_UP: begin
        act_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_DOWN: begin
        act_d      = 1'b1;
        up_dwn_n_d = 1'b0;
        busy_d     = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      ST_ERR: begin
        up_dwn_n_d = up_dwn_n_q;
        err_d      = 1'b1;
      end
      default: ;
    endcase
  end

  assign act        = act_q;
  assign up_dwn_n   = up_dwn_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign loops_done = loops_done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with an attached up/down counter model and an
// event scoreboard (direction turns, done pulses, error entries).
module tb_sweep_ctrl;

  localparam int CW = 4;
  localparam int LW = 4;
  localparam int TO = 16;

  localparam logic [1:0] EV_FALL = 2'd0;
  localparam logic [1:0] EV_RISE = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [CW-1:0] cnt;
    logic [LW-1:0] ld;
    logic [1:0]    code;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] hi_lim, lo_lim;
  logic [LW-1:0] loops;
  logic [CW-1:0] count_in;
  logic          ovflw_in;
  logic          act, up_dwn_n, busy, done, err;
  logic [1:0]    err_code;
  logic [LW-1:0] loops_done;

  logic          use_model;
  logic [CW-1:0] force_cnt;
  logic [CW-1:0] model_cnt;

  int  vectors     = 0;
  int  miscompares = 0;
  ev_t sb_q[$];

  logic mon_en = 1'b0;
  logic ud_prev, err_prev;
  ev_t  mon_obs, mon_exp;
  logic mon_hit;

  always #5 clk = ~clk;

  sweep_ctrl #(
    .COUNTER_WIDTH  (CW),
    .LOOP_WIDTH     (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hi_lim     (hi_lim),
    .lo_lim     (lo_lim),
    .loops      (loops),
    .count_in   (count_in),
    .ovflw_in   (ovflw_in),
    .act        (act),
    .up_dwn_n   (up_dwn_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .loops_done (loops_done)
  );

  // Up/down counter model driven by the DUT's registered controls.
  always_ff @(posedge clk) begin
    if (rst)      model_cnt <= '0;
    else if (act) model_cnt <= up_dwn_n ? model_cnt + 1'b1 : model_cnt - 1'b1;
  end

  assign count_in = use_model ? model_cnt : force_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] kind, input int cnt, input int ld, input logic [1:0] code);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt[CW-1:0];
    e.ld   = ld[LW-1:0];
    e.code = code;
    return e;
  endfunction

  // Event monitor: every observed event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_hit = 1'b0;
      mon_obs = '0;
      if (err && !err_prev) begin
        mon_obs = mk(EV_ERR, int'(count_in), int'(loops_done), err_code);
        mon_hit = 1'b1;
      end else if (done) begin
        mon_obs = mk(EV_DONE, int'(count_in), int'(loops_done), err_code);
        mon_hit = 1'b1;
      end else if (up_dwn_n !== ud_prev) begin
        mon_obs = mk(up_dwn_n ? EV_RISE : EV_FALL, int'(count_in), int'(loops_done), err_code);
        mon_hit = 1'b1;
      end
      if (mon_hit) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_event", 32'(mon_obs), 32'hFFFF_FFFF);
        end else begin
          mon_exp = sb_q.pop_front();
          chk("sb_event", 32'(mon_obs), 32'(mon_exp));
        end
      end
    end
    ud_prev  = up_dwn_n;
    err_prev = err;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic start_sweep(input int h, input int l, input int n);
    hi_lim = h[CW-1:0];
    lo_lim = l[CW-1:0];
    loops  = n[LW-1:0];
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // sel 0: up_dwn_n low, 1: done high, otherwise count_in == val.
  task automatic wait_for(input string tag, input int sel, input int val, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      case (sel)
        0:       found = (up_dwn_n === 1'b0);
        1:       found = (done === 1'b1);
        default: found = (count_in === val[CW-1:0]);
      endcase
    end
    chk({tag, "_reached"}, 32'(found), 32'd1);
  endtask

  initial begin
    int first_err;
    rst       = 1'b1;
    start     = 1'b0;
    hi_lim    = '0;
    lo_lim    = '0;
    loops     = '0;
    ovflw_in  = 1'b0;
    use_model = 1'b1;
    force_cnt = '0;
    repeat (2) step();
    rst = 1'b0;

    chk("rst_act",        32'(act),        32'd0);
    chk("rst_up_dwn_n",   32'(up_dwn_n),   32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_err_code",   32'(err_code),   32'd0);
    chk("rst_loops_done", 32'(loops_done), 32'd0);
    mon_en = 1'b1;

    // Normal two-loop sweep: turns land one count past each limit.
    do_reset();
    sb_q.push_back(mk(EV_FALL, 6, 0, 2'd0));
    sb_q.push_back(mk(EV_RISE, 1, 1, 2'd0));
    sb_q.push_back(mk(EV_FALL, 6, 1, 2'd0));
    sb_q.push_back(mk(EV_DONE, 1, 2, 2'd0));
    start_sweep(5, 2, 2);
    chk("sw_act_latency", 32'(act),      32'd1);
    chk("sw_busy",        32'(busy),     32'd1);
    chk("sw_up",          32'(up_dwn_n), 32'd1);
    wait_for("sw_done", 1, 0, 60);
    chk("sw_loops_done",  32'(loops_done), 32'd2);
    chk("sw_err",         32'(err),        32'd0);
    chk("sw_done_act",    32'(act),        32'd0);
    chk("sw_done_busy",   32'(busy),       32'd0);
    step();
    chk("sw_done_1cyc",   32'(done),       32'd0);

    // Bad limits (hi == lo).
    do_reset();
    sb_q.push_back(mk(EV_ERR, 0, 0, 2'd1));
    start_sweep(3, 3, 1);
    chk("lim_err",      32'(err),      32'd1);
    chk("lim_err_code", 32'(err_code), 32'd1);
    chk("lim_act",      32'(act),      32'd0);
    chk("lim_busy",     32'(busy),     32'd0);
    repeat (3) step();
    chk("lim_act_hold", 32'(act),      32'd0);
    chk("lim_err_hold", 32'(err),      32'd1);

    // Zero loops, with an overflow in IDLE that must be ignored.
    do_reset();
    ovflw_in = 1'b1;
    step();
    ovflw_in = 1'b0;
    chk("idle_ovflw_ignored", 32'(err), 32'd0);
    sb_q.push_back(mk(EV_DONE, 0, 0, 2'd0));
    start_sweep(7, 1, 0);
    chk("z_done",       32'(done),       32'd1);
    chk("z_act",        32'(act),        32'd0);
    chk("z_loops_done", 32'(loops_done), 32'd0);
    step();
    chk("z_done_1cyc",  32'(done),       32'd0);
    chk("z_act_after",  32'(act),        32'd0);

    // Overflow coincident with count_in == hi wins over the turn.
    do_reset();
    sb_q.push_back(mk(EV_ERR, 6, 0, 2'd2));
    start_sweep(5, 2, 1);
    wait_for("ov_cnt5", 2, 5, 20);
    chk("ov_pre_up",  32'(up_dwn_n), 32'd1);
    chk("ov_pre_act", 32'(act),      32'd1);
    ovflw_in = 1'b1;
    step();
    ovflw_in = 1'b0;
    chk("ov_err",      32'(err),      32'd1);
    chk("ov_err_code", 32'(err_code), 32'd2);
    chk("ov_act",      32'(act),      32'd0);
    chk("ov_not_down", 32'(up_dwn_n), 32'd1);
    chk("ov_busy",     32'(busy),     32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("ov_err_sticky",  32'(err),      32'd1);
    chk("ov_code_frozen", 32'(err_code), 32'd2);
    chk("ov_act_sticky",  32'(act),      32'd0);

    // Reset during DOWN, then a fresh single-loop sweep down to zero.
    do_reset();
    sb_q.push_back(mk(EV_FALL, 6, 0, 2'd0));
    start_sweep(5, 2, 2);
    wait_for("rd_down", 0, 0, 20);
    repeat (2) step();
    sb_q.push_back(mk(EV_RISE, 0, 0, 2'd0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_act",        32'(act),        32'd0);
    chk("rd_up_dwn_n",   32'(up_dwn_n),   32'd1);
    chk("rd_busy",       32'(busy),       32'd0);
    chk("rd_done",       32'(done),       32'd0);
    chk("rd_err",        32'(err),        32'd0);
    chk("rd_err_code",   32'(err_code),   32'd0);
    chk("rd_loops_done", 32'(loops_done), 32'd0);
    sb_q.push_back(mk(EV_FALL, 5, 0, 2'd0));
    sb_q.push_back(mk(EV_DONE, 15, 1, 2'd0));
    start_sweep(4, 0, 1);
    wait_for("rd2_done", 1, 0, 40);
    chk("rd2_loops_done", 32'(loops_done), 32'd1);
    chk("rd2_err",        32'(err),        32'd0);

    // Counter stuck at 3 while sweeping up.
    do_reset();
    use_model = 1'b0;
    force_cnt = 4'd3;
    first_err = 0;
`ifdef SWEEP_TIMEOUT_EN
    sb_q.push_back(mk(EV_ERR, 3, 0, 2'd3));
`endif
    start_sweep(7, 1, 1);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (err === 1'b1 && first_err == 0) first_err = k;
    end
`ifdef SWEEP_TIMEOUT_EN
    chk("to_cycle",    32'(first_err), 32'd17);
    chk("to_err_code", 32'(err_code),  32'd3);
    chk("to_act",      32'(act),       32'd0);
`else
    chk("to_no_err",   32'(first_err), 32'd0);
    chk("to_act",      32'(act),       32'd1);
    chk("to_up",       32'(up_dwn_n),  32'd1);
    chk("to_busy",     32'(busy),      32'd1);
`endif
    do_reset();
    use_model = 1'b1;
    step();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Initiator FSM that drives the act/up_dwn_n control pair of the team's up/down counter.
- Monitors the counter's count and ovflw outputs, and runs a programmed triangle sweep: count up to hi_lim, count down to lo_lim, repeated a programmed number of times.
- Handshakes to a host via a start pulse plus busy/done/err.
- Sits between the test/host logic and the counter instance.

Parameters:
- COUNTER_WIDTH, 4, width of count_in, hi_lim and lo_lim; must match the driven counter.
- LOOP_WIDTH, 4, width of loops and of the internal loop counter.
- TIMEOUT_CYCLES, 16, watchdog limit; used only when SWEEP_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- hi_lim  input  COUNTER_WIDTH  upper turn point; captured on accepted start.
- lo_lim  input  COUNTER_WIDTH  lower turn point; captured on accepted start.
- loops  input  LOOP_WIDTH  number of up/down cycles; captured on accepted start.
- count_in  input  COUNTER_WIDTH  counter's count output.
- ovflw_in  input  1  counter's ovflw output.
- act  output  1  counter activate, registered.
- up_dwn_n  output  1  1 = count up, 0 = count down, registered.
- busy  output  1  high in UP/DOWN.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 bad limits, 10 counter overflow, 11 timeout.
- loops_done  output  LOOP_WIDTH  completed loop count.

Behaviour:
- All state and outputs are registered and update on the rising clk edge.
- Reset values (rst=1 at an edge): state=IDLE, act=0, up_dwn_n=1, busy=0, done=0, err=0, err_code=00, loops_done=0, hi_q=lo_q=loops_q=0.
- rst mid-sweep aborts immediately, with the same values as above.
- States: IDLE, UP, DOWN, DONE, ERR. One-hot encoding.
- IDLE, start=1:
  - capture hi_q/lo_q/loops_q and clear loops_done.
  - hi_lim <= lo_lim (unsigned): go to ERR, err_code=01.
  - else loops==0: go to DONE, act stays 0.
  - else: go to UP; act=1 and up_dwn_n=1 from the next cycle. Start-to-act latency is 1 cycle.
- start outside IDLE is ignored.
- UP: count_in >= hi_q -> DOWN; up_dwn_n=0 from the next cycle, act stays 1.
- DOWN, count_in <= lo_q:
  - loops_done increments.
  - if the incremented value == loops_q -> DONE, act=0 next cycle.
  - else -> UP, up_dwn_n=1.
- Comparisons are unsigned and full-width. The comparisons use >= and <= so that counter pipeline overshoot of 1-2 counts still turns the sweep.
- DONE: done=1 for exactly one cycle, act=0, then IDLE. busy is 0 in DONE.
- ovflw_in=1 while in UP or DOWN -> ERR with err_code=10. This has priority over the turn/loop transitions in the same cycle.
- ovflw_in in IDLE/DONE is ignored.
- ERR: act=0, busy=0, err=1, up_dwn_n holds. err_code is frozen at the first error. ERR exits only via rst, matching the counter's sticky overflow, which also needs reset.
- loops_done saturates at loops_q and never wraps.

Optional Feature:
- Macro SWEEP_TIMEOUT_EN.
- Defined:
  - a watchdog counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles in UP/DOWN in which count_in equals its previous-cycle value.
  - it clears on any count_in change or state change.
  - reaching TIMEOUT_CYCLES -> ERR with err_code=11. ovflw has priority if both occur in the same cycle.
- Undefined: no watchdog logic; code 11 is never produced; TIMEOUT_CYCLES is unused.

Decomposition:
- Package sweep_pkg holds:
  - state localparams (IDLE/UP/DOWN/DONE/ERR one-hot).
  - err_code constants ERR_NONE/ERR_LIMITS/ERR_OVFLW/ERR_TIMEOUT.
- One natural sub-module, sweep_watchdog: the stall counter, instantiated only under SWEEP_TIMEOUT_EN.
- Everything else stays flat in sweep_ctrl.

Test Plan:
- hi=5, lo=2, loops=2, counter model attached:
  - act rises 1 cycle after start.
  - up_dwn_n falls after count_in>=5 and rises after count_in<=2.
  - loops_done goes 1 then 2; done pulses exactly once; err=0.
- hi=3, lo=3, start -> next cycle err=1, err_code=01, act never asserted, busy=0.
- loops=0, hi=7, lo=1 -> done pulse 1 cycle after start, act stays 0, loops_done=0.
- Force ovflw_in=1 mid-UP, in the same cycle as count_in==hi -> ERR with err_code=10 (not DOWN), act=0 next cycle. Remains in ERR until rst.
- rst=1 for one cycle during DOWN -> next cycle all outputs at reset values. A new start with hi=4, lo=0, loops=1 then completes normally.
- SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=16, count_in held at 3 in UP -> ERR with err_code=11 on the 16th stalled cycle. Without the macro, the same stimulus stays in UP indefinitely.
